// File: rtl/eq_gain_pkg.sv
// Shared types and width helpers for the equalizer gain mixer.
package eq_gain_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MAC,
        DRAIN,
        SCALE,
        DONE
    } state_t;

    localparam int unsigned SAT_MAX_W = 128;

    function automatic int unsigned prod_w(input int unsigned in_w, input int unsigned gain_w);
        return in_w + gain_w;
    endfunction

    // Guard bits cover the worst-case sum of NUM_BANDS full-scale products.
    function automatic int unsigned acc_w(input int unsigned in_w, input int unsigned gain_w,
                                          input int unsigned num_bands);
        return in_w + gain_w + $clog2(num_bands);
    endfunction

    function automatic logic signed [SAT_MAX_W-1:0] saturate(input logic signed [SAT_MAX_W-1:0] v,
                                                             input int unsigned out_w);
        logic signed [SAT_MAX_W-1:0] hi;
        logic signed [SAT_MAX_W-1:0] lo;
        hi = (SAT_MAX_W'(1) <<< (out_w - 1)) - SAT_MAX_W'(1);
        lo = ~hi;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/eq_gain_bank.sv
// Double-buffered gain storage: shadow bank written any cycle, active bank
// refreshed from shadow only at sample capture when a commit is pending.
module eq_gain_bank
    import eq_gain_pkg::*;
#(
    parameter int unsigned NUM_BANDS    = 4,
    parameter int unsigned NUM_CHANNELS = 2,
    parameter int unsigned GAIN_W       = 16,
    parameter int unsigned CH_W         = 1,
    parameter int unsigned BAND_W       = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              gain_wr,
    input  logic [CH_W-1:0]   gain_wr_ch,
    input  logic [BAND_W-1:0] gain_wr_band,
    input  logic [GAIN_W-1:0] gain_wr_data,
    input  logic              gain_commit,
    input  logic              capture,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [BAND_W-1:0] rd_band,
    output logic [GAIN_W-1:0] rd_gain
);

    logic [GAIN_W-1:0] shadow_q [NUM_CHANNELS][NUM_BANDS];
    logic [GAIN_W-1:0] shadow_d [NUM_CHANNELS][NUM_BANDS];
    logic [GAIN_W-1:0] active_q [NUM_CHANNELS][NUM_BANDS];
    logic              commit_pending;

    // Same-cycle write is folded in before any copy so a simultaneous commit includes it.
    always_comb begin
        shadow_d = shadow_q;
        if (gain_wr && (32'(gain_wr_ch) < NUM_CHANNELS) && (32'(gain_wr_band) < NUM_BANDS))
            shadow_d[gain_wr_ch][gain_wr_band] = gain_wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q       <= '{default: '0};
            active_q       <= '{default: '0};
            commit_pending <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            if (capture && (commit_pending || gain_commit))
                active_q <= shadow_d;
            if (capture)
                commit_pending <= 1'b0;
            else if (gain_commit)
                commit_pending <= 1'b1;
        end
    end

    assign rd_gain = active_q[rd_ch][rd_band];

endmodule

// File: rtl/eq_gain_mixer.sv
// Per-channel weighted band sum, output scaling and OUT_W delivery.
// Build option: EQ_GAIN_MIXER_SATURATE_EN selects clamping (with clip flag) instead of wrap.
module eq_gain_mixer
    import eq_gain_pkg::*;
#(
    parameter int unsigned NUM_BANDS    = 4,
    parameter int unsigned NUM_CHANNELS = 2,
    parameter int unsigned IN_W         = 48,
    parameter int unsigned GAIN_W       = 16,
    parameter int unsigned SCALE_W      = 13,
    parameter int unsigned OUT_W        = 24,
    parameter int unsigned OUT_SHIFT    = 36,
    localparam int unsigned CH_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    localparam int unsigned BAND_W      = $clog2(NUM_BANDS)
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  run,
    input  logic                                  in_valid,
    input  logic [NUM_CHANNELS*NUM_BANDS*IN_W-1:0] in_data,
    input  logic [SCALE_W-1:0]                    scale_value,
    input  logic                                  gain_wr,
    input  logic [CH_W-1:0]                       gain_wr_ch,
    input  logic [BAND_W-1:0]                     gain_wr_band,
    input  logic [GAIN_W-1:0]                     gain_wr_data,
    input  logic                                  gain_commit,
    input  logic                                  status_clr,
    output logic                                  busy,
    output logic                                  out_valid,
    output logic [NUM_CHANNELS*OUT_W-1:0]         out_data,
    output logic                                  overrun,
    output logic                                  clip
);

    localparam int unsigned PROD_W = prod_w(IN_W, GAIN_W);
    localparam int unsigned ACC_W  = acc_w(IN_W, GAIN_W, NUM_BANDS);
    localparam int unsigned SC_W   = ACC_W + SCALE_W + 1;

    state_t                                state;
    state_t                                state_d;
    logic [CH_W-1:0]                       ch;
    logic [BAND_W-1:0]                     band;
    logic [NUM_CHANNELS*NUM_BANDS*IN_W-1:0] data_q;
    logic [SCALE_W-1:0]                    scale_q;
    logic signed [PROD_W-1:0]              prod_q;
    logic signed [PROD_W-1:0]              prod_d;
    logic                                  prod_vld;
    logic signed [ACC_W-1:0]               acc;
    logic [OUT_W-1:0]                      res_q [NUM_CHANNELS];
    logic [GAIN_W-1:0]                     gain_rd;
    logic signed [IN_W-1:0]                d_sel;
    logic signed [SC_W-1:0]                scaled;
    logic [OUT_W-1:0]                      y_out;
    logic                                  y_clip;
    logic                                  capture;
    logic                                  last_band;
    logic                                  last_ch;

    eq_gain_bank #(
        .NUM_BANDS   (NUM_BANDS),
        .NUM_CHANNELS(NUM_CHANNELS),
        .GAIN_W      (GAIN_W),
        .CH_W        (CH_W),
        .BAND_W      (BAND_W)
    ) u_bank (
        .clk         (clk),
        .reset_n     (reset_n),
        .gain_wr     (gain_wr),
        .gain_wr_ch  (gain_wr_ch),
        .gain_wr_band(gain_wr_band),
        .gain_wr_data(gain_wr_data),
        .gain_commit (gain_commit),
        .capture     (capture),
        .rd_ch       (ch),
        .rd_band     (band),
        .rd_gain     (gain_rd)
    );

    always_comb begin
        capture   = (state == IDLE) && run && in_valid;
        last_band = (band == BAND_W'(NUM_BANDS - 1));
        last_ch   = (ch == CH_W'(NUM_CHANNELS - 1));
        d_sel     = data_q[(32'(ch) * NUM_BANDS + 32'(band)) * IN_W +: IN_W];
        prod_d    = PROD_W'(d_sel) * PROD_W'($signed(gain_rd));
        scaled    = SC_W'(acc) * SC_W'($signed({1'b0, scale_q}));
    end

`ifdef EQ_GAIN_MIXER_SATURATE_EN
    logic signed [SAT_MAX_W-1:0] y_wide;
    logic signed [SAT_MAX_W-1:0] y_sat;

    always_comb begin
        y_wide = SAT_MAX_W'(scaled >>> OUT_SHIFT);
        y_sat  = saturate(y_wide, OUT_W);
        y_out  = y_sat[OUT_W-1:0];
        y_clip = (y_sat != y_wide);
    end
`else
    always_comb begin
        y_out  = OUT_W'(scaled >>> OUT_SHIFT);
        y_clip = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (!run) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_valid) state_d = MAC;
                MAC:     if (last_band) state_d = DRAIN;
                DRAIN:   state_d = SCALE;
                SCALE:   state_d = last_ch ? DONE : MAC;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state != IDLE);
        out_valid = (state == DONE);
    end

    // The last channel's result is bypassed into out_data so all channels appear with out_valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ch       <= '0;
            band     <= '0;
            data_q   <= '0;
            scale_q  <= '0;
            prod_q   <= '0;
            prod_vld <= 1'b0;
            acc      <= '0;
            res_q    <= '{default: '0};
            out_data <= '0;
        end else begin
            prod_vld <= (state == MAC);
            if (state == MAC) begin
                prod_q <= prod_d;
                band   <= band + 1'b1;
            end
            if (prod_vld)
                acc <= acc + ACC_W'(prod_q);
            if (capture) begin
                data_q  <= in_data;
                scale_q <= scale_value;
                ch      <= '0;
                band    <= '0;
                acc     <= '0;
            end
            if ((state == SCALE) && run) begin
                res_q[ch] <= y_out;
                if (!last_ch) begin
                    ch   <= ch + 1'b1;
                    band <= '0;
                    acc  <= '0;
                end else begin
                    for (int unsigned c = 0; c < NUM_CHANNELS; c++)
                        out_data[c*OUT_W +: OUT_W] <= (32'(ch) == c) ? y_out : res_q[c];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
            clip    <= 1'b0;
        end else begin
            if (run && in_valid && (state != IDLE))
                overrun <= 1'b1;
            else if (status_clr)
                overrun <= 1'b0;
            if ((state == SCALE) && run && y_clip)
                clip <= 1'b1;
            else if (status_clr)
                clip <= 1'b0;
        end
    end

endmodule

// File: tb/tb_eq_gain_mixer.sv
// Scoreboard bench for eq_gain_mixer with an arithmetic reference model.
module tb_eq_gain_mixer;

    localparam int NB        = 4;
    localparam int NC        = 2;
    localparam int IN_W      = 48;
    localparam int GAIN_W    = 16;
    localparam int SCALE_W   = 13;
    localparam int OUT_W     = 24;
    localparam int OUT_SHIFT = 36;
    localparam int CHW       = 1;
    localparam int BW        = 2;
    localparam int LAT       = 1 + NC * (NB + 2);

    typedef logic signed [IN_W-1:0] smp_t [NC][NB];
    typedef struct {
        logic [NC*OUT_W-1:0] data;
        int                  cyc;
        bit                  clip;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic                     run;
    logic                     in_valid;
    logic [NC*NB*IN_W-1:0]    in_data;
    logic [SCALE_W-1:0]       scale_value;
    logic                     gain_wr;
    logic [CHW-1:0]           gain_wr_ch;
    logic [BW-1:0]            gain_wr_band;
    logic [GAIN_W-1:0]        gain_wr_data;
    logic                     gain_commit;
    logic                     status_clr;
    logic                     busy;
    logic                     out_valid;
    logic [NC*OUT_W-1:0]      out_data;
    logic                     overrun;
    logic                     clip;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    exp_t                     sbq[$];
    logic signed [GAIN_W-1:0] m_shadow [NC][NB];
    logic signed [GAIN_W-1:0] m_active [NC][NB];
    bit                       m_pending;
    bit                       m_clip;
    logic [NC*OUT_W-1:0]      m_out;

    eq_gain_mixer #(
        .NUM_BANDS   (NB),
        .NUM_CHANNELS(NC),
        .IN_W        (IN_W),
        .GAIN_W      (GAIN_W),
        .SCALE_W     (SCALE_W),
        .OUT_W       (OUT_W),
        .OUT_SHIFT   (OUT_SHIFT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .run         (run),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .scale_value (scale_value),
        .gain_wr     (gain_wr),
        .gain_wr_ch  (gain_wr_ch),
        .gain_wr_band(gain_wr_band),
        .gain_wr_data(gain_wr_data),
        .gain_commit (gain_commit),
        .status_clr  (status_clr),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .overrun     (overrun),
        .clip        (clip)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: weighted sum, scale, shift, then clamp or wrap to OUT_W.
    function automatic void model_calc(input smp_t d, input logic [SCALE_W-1:0] sc,
                                       output logic [NC*OUT_W-1:0] o, output bit clipped);
        logic signed [159:0] sum, y, scv, hi, lo;
        o       = '0;
        clipped = 1'b0;
        scv     = 160'(sc);
        hi      = (160'sd1 <<< (OUT_W - 1)) - 160'sd1;
        lo      = -hi - 160'sd1;
        for (int c = 0; c < NC; c++) begin
            sum = '0;
            for (int b = 0; b < NB; b++)
                sum = sum + 160'(d[c][b]) * 160'(m_active[c][b]);
            y = (sum * scv) >>> OUT_SHIFT;
`ifdef EQ_GAIN_MIXER_SATURATE_EN
            if (y > hi) begin
                y = hi; clipped = 1'b1;
            end else if (y < lo) begin
                y = lo; clipped = 1'b1;
            end
`endif
            o[c*OUT_W +: OUT_W] = y[OUT_W-1:0];
        end
    endfunction

    function automatic logic [NC*NB*IN_W-1:0] pack(input smp_t d);
        logic [NC*NB*IN_W-1:0] v;
        for (int c = 0; c < NC; c++)
            for (int b = 0; b < NB; b++)
                v[(c*NB+b)*IN_W +: IN_W] = d[c][b];
        return v;
    endfunction

    task automatic set_all(output smp_t d, input logic signed [IN_W-1:0] v);
        for (int c = 0; c < NC; c++)
            for (int b = 0; b < NB; b++)
                d[c][b] = v;
    endtask

    task automatic rand_smp(output smp_t d);
        for (int c = 0; c < NC; c++)
            for (int b = 0; b < NB; b++) begin
                d[c][b] = IN_W'({$urandom(), $urandom()});
                d[c][b] = d[c][b] >>> $urandom_range(0, 40);
            end
    endtask

    task automatic wr_gain(input int c, input int b, input logic [GAIN_W-1:0] g, input bit commit);
        gain_wr      = 1'b1;
        gain_wr_ch   = CHW'(c);
        gain_wr_band = BW'(b);
        gain_wr_data = g;
        gain_commit  = commit;
        m_shadow[c][b] = g;
        if (commit) m_pending = 1'b1;
        step();
        gain_wr     = 1'b0;
        gain_commit = 1'b0;
    endtask

    task automatic gains_all(input logic [GAIN_W-1:0] g);
        for (int c = 0; c < NC; c++)
            for (int b = 0; b < NB; b++)
                wr_gain(c, b, g, (c == NC-1) && (b == NB-1));
    endtask

    // cap: the DUT will capture this strobe; push: a result is expected.
    task automatic issue(input smp_t d, input logic [SCALE_W-1:0] sc, input bit cap, input bit push);
        exp_t e;
        logic [NC*OUT_W-1:0] o;
        bit cl;
        in_data     = pack(d);
        scale_value = sc;
        in_valid    = 1'b1;
        if (cap) begin
            if (m_pending) begin
                m_active  = m_shadow;
                m_pending = 1'b0;
            end
            if (push) begin
                model_calc(d, sc, o, cl);
                m_clip = m_clip | cl;
                e.data = o;
                e.clip = m_clip;
                e.cyc  = cyc + LAT;
                sbq.push_back(e);
                m_out = o;
            end
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (sbq.size() != 0 && t < 60) begin
            step();
            t++;
        end
        if (sbq.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL out_valid_timeout: got none after %0d cycles, expected %0d pending", t, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++)
            for (int b = 0; b < NB; b++) begin
                m_shadow[c][b] = '0;
                m_active[c][b] = '0;
            end
        m_pending = 1'b0;
        m_clip    = 1'b0;
        m_out     = '0;
        sbq.delete();
    endtask

    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            if (sbq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_out_valid: got out_data %h at cycle %0d, expected no strobe", out_data, cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("out_data", out_data, e.data);
                check("latency", cyc, e.cyc);
                check("clip_flag", clip, e.clip);
                check("busy_at_valid", busy, 1'b1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected $finish");
        $fatal(1);
    end

    initial begin
        smp_t d;
        reset_n = 1'b0; run = 1'b1; in_valid = 1'b0; in_data = '0; scale_value = '0;
        gain_wr = 1'b0; gain_wr_ch = '0; gain_wr_band = '0; gain_wr_data = '0;
        gain_commit = 1'b0; status_clr = 1'b0;
        model_reset();
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_clip", clip, 1'b0);
        #5 reset_n = 1'b1;
        step();

        // Unity path
        gains_all(16'h1000);
        set_all(d, 48'sd16777216);
        check("idle_busy", busy, 1'b0);
        issue(d, 13'd1, 1'b1, 1'b1);
        check("busy_cycle1", busy, 1'b1);
        wait_done();
        check("busy_after", busy, 1'b0);
        check("unity_const", out_data, {24'd4, 24'd4});

        // Per-channel gains and scaling
        for (int b = 0; b < NB; b++) wr_gain(0, b, (b == 0) ? 16'h1000 : 16'h0000, 1'b0);
        for (int b = 0; b < NB; b++) wr_gain(1, b, (b == NB-1) ? 16'h2000 : 16'h0000, b == NB-1);
        issue(d, 13'd4096, 1'b1, 1'b1);
        wait_done();
        check("perch_const", out_data, {24'd8192, 24'd4096});

        // Saturation / wrap
        gains_all(16'h7FFF);
        set_all(d, 48'sh7FFF_FFFF_FFFF);
        issue(d, 13'd8191, 1'b1, 1'b1);
        wait_done();
`ifdef EQ_GAIN_MIXER_SATURATE_EN
        check("sat_pos_const", out_data, {24'h7FFFFF, 24'h7FFFFF});
        check("sat_clip", clip, 1'b1);
`else
        check("wrap_clip", clip, 1'b0);
`endif
        set_all(d, -48'sh7FFF_FFFF_FFFF);
        issue(d, 13'd8191, 1'b1, 1'b1);
        wait_done();
`ifdef EQ_GAIN_MIXER_SATURATE_EN
        check("sat_neg_const", out_data, {24'h800000, 24'h800000});
`endif
        status_clr = 1'b1; m_clip = 1'b0;
        step();
        status_clr = 1'b0;
        check("clip_cleared", clip, 1'b0);

        // Commit boundary: update mid-sample, write+commit on the same cycle
        gains_all(16'h1000);
        rand_smp(d);
        issue(d, 13'd2048, 1'b1, 1'b1);
        for (int c = 0; c < NC; c++)
            for (int b = 0; b < NB; b++)
                wr_gain(c, b, 16'h0800 + 16'(c*NB + b), (c == NC-1) && (b == NB-1));
        wait_done();
        rand_smp(d);
        issue(d, 13'd2048, 1'b1, 1'b1);
        wait_done();
        wr_gain(0, 0, 16'h4000, 1'b0);
        issue(d, 13'd2048, 1'b1, 1'b1);
        wait_done();

        // Overrun
        rand_smp(d);
        issue(d, 13'd1000, 1'b1, 1'b1);
        repeat (4) step();
        set_all(d, 48'sd12345);
        issue(d, 13'd1000, 1'b0, 1'b0);
        check("overrun_set", overrun, 1'b1);
        wait_done();
        repeat (16) step();
        status_clr = 1'b1;
        step();
        status_clr = 1'b0;
        check("overrun_cleared", overrun, 1'b0);

        // Abort via run low; commit is consumed at the aborted capture
        gains_all(16'h0300);
        rand_smp(d);
        issue(d, 13'd777, 1'b1, 1'b0);
        repeat (5) step();
        run = 1'b0;
        step();
        run = 1'b1;
        repeat (20) step();
        check("abort_busy", busy, 1'b0);
        check("abort_hold", out_data, m_out);
        issue(d, 13'd777, 1'b1, 1'b1);
        wait_done();

        // Randomized samples
        for (int it = 0; it < 12; it++) begin
            int nw;
            nw = $urandom_range(0, 5);
            for (int k = 0; k < nw; k++)
                wr_gain($urandom_range(0, NC-1), $urandom_range(0, NB-1), GAIN_W'($urandom()),
                        $urandom_range(0, 1) == 1);
            rand_smp(d);
            issue(d, SCALE_W'($urandom()), 1'b1, 1'b1);
            wait_done();
        end

        // Asynchronous reset mid-MAC
        gains_all(16'h1234);
        rand_smp(d);
        issue(d, 13'd100, 1'b1, 1'b0);
        issue(d, 13'd100, 1'b0, 1'b0);
        step();
        #3 reset_n = 1'b0;
        #1;
        check("amid_busy", busy, 1'b0);
        check("amid_out_valid", out_valid, 1'b0);
        check("amid_out_data", out_data, '0);
        check("amid_overrun", overrun, 1'b0);
        check("amid_clip", clip, 1'b0);
        model_reset();
        #2 reset_n = 1'b1;
        step();
        rand_smp(d);
        issue(d, 13'd500, 1'b1, 1'b1);
        wait_done();
        check("post_reset_zero_gain", out_data, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/eq_gain_mixer.md
# eq_gain_mixer

- Weights and sums the per-band outputs of the equalizer filter bank for every audio channel, then applies a global output scaler and delivers one `OUT_W`-bit sample per channel.
- Parametrised successor to the fixed 4-band stereo gain stage, generalised in band count, channel count and widths. Sits between the band filter bank and the output formatter / I2S path.
- New behaviour over the fixed stage: per-channel gains, glitch-free double-buffered gain updates, output saturation, and overrun/clip status.

## Interface
- `NUM_BANDS`, 4, filter bands per channel (2..16)
- `NUM_CHANNELS`, 2, audio channels (1..8)
- `IN_W`, 48, signed band-sample width
- `GAIN_W`, 16, signed gain width
- `SCALE_W`, 13, unsigned output-scale width
- `OUT_W`, 24, signed output width
- `OUT_SHIFT`, 36, arithmetic right shift applied after scaling
- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous active-low reset
- `run`  in  1  enable; when low the FSM is forced to IDLE and in_valid is ignored
- `in_valid`  in  1  one-cycle strobe; in_data is complete for all channels and bands
- `in_data`  in  NUM_CHANNELS*NUM_BANDS*IN_W  flattened; index = ch*NUM_BANDS+band
- `scale_value`  in  SCALE_W  output scale; sampled at capture
- `gain_wr`  in  1  write strobe to the shadow gain bank
- `gain_wr_ch`  in  $clog2(NUM_CHANNELS) (min 1)  channel select
- `gain_wr_band`  in  $clog2(NUM_BANDS)  band select
- `gain_wr_data`  in  GAIN_W  gain value
- `gain_commit`  in  1  strobe; shadow bank becomes active at the next capture
- `status_clr`  in  1  clears the sticky flags
- `busy`  out  1  high from capture until out_valid; reset 0
- `out_valid`  out  1  one-cycle strobe; reset 0
- `out_data`  out  NUM_CHANNELS*OUT_W  flattened outputs, held between strobes; reset 0
- `overrun`  out  1  sticky; in_valid arrived while busy; reset 0
- `clip`  out  1  sticky; any output saturated; reset 0

## Operation
- **IDLE:** on in_valid & run, register all of in_data and scale_value.
  - If commit_pending, copy shadow→active and clear commit_pending.
  - Go to MAC with ch=0, band=0, acc=0.
- **MAC:** one band per cycle, product p = data×gain (signed, IN_W+GAIN_W bits, one register stage).
  - The accumulator adds the registered p. ACC_W = IN_W+GAIN_W+$clog2(NUM_BANDS); the accumulator never wraps.
  - After band NUM_BANDS-1, go to DRAIN.
- **DRAIN:** one cycle for the last product to land, then go to SCALE.
- **SCALE:** y = (acc × scale_value) >>> OUT_SHIFT, then saturate to OUT_W and write the channel's result register.
  - If ch<NUM_CHANNELS-1: ch++, band=0, acc=0, go to MAC.
  - Otherwise go to DONE.
- **DONE:** copy all channel result registers to out_data together, pulse out_valid, return to IDLE.
- **Gains:**
  - gain_wr writes the shadow bank any cycle. Active gains never change mid-sample.
  - gain_commit sets commit_pending; it is consumed only at capture.
  - gain_wr and gain_commit on the same cycle: the write lands first and is included in the commit.
- **Overrun:** in_valid while busy sets overrun; that sample is dropped and the current computation is not disturbed.
- **run low mid-operation:** abort to IDLE, busy=0, no out_valid. out_data, the gain banks and commit_pending are retained.
- **Status:** status_clr and a new set event on the same cycle leave the flag set.
- **Reset values:** active and shadow gains reset to 0.

## Timing
- Latency from in_valid (cycle 0) to out_valid = 1 + NUM_CHANNELS×(NUM_BANDS+2). Defaults: 13 cycles.
- busy rises the cycle after capture and falls with out_valid.
- A new in_valid is accepted in the cycle following out_valid.
- Minimum sample period = latency+1 cycles.

## Configuration
- `EQ_GAIN_MIXER_SATURATE_EN` defined: SCALE clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and sets clip when clamping.
- Not defined: SCALE truncates to the low OUT_W bits (two's-complement wrap) and clip is tied to 0.

## Structure
- Package `eq_gain_pkg` holds:
  - the FSM state enum: IDLE, MAC, DRAIN, SCALE, DONE;
  - the ACC_W/PROD_W width functions;
  - the saturate function.
- Sub-module `eq_gain_bank` holds the shadow and active NUM_CHANNELS×NUM_BANDS gain arrays. It has the write port, the commit/copy logic and an asynchronous read port indexed by (ch, band).
- The multiplier, accumulator and FSM stay in the top module.

## Test plan
- Unity path: all bands 2^24, gains 0x1000 on both channels, scale 1, one in_valid -> out_valid at cycle 13, both outputs 4, busy high for cycles 1..13.
- Per-channel gains and scaling: ch0 gains {0x1000,0,0,0}, ch1 {0,0,0,0x2000}, data 2^24, scale 4096 -> ch0 = 4096, ch1 = 8192.
- Saturation, SATURATE_EN: data 2^47-1, gains 0x7FFF, scale 8191 -> out 0x7FFFFF, clip=1. Negated data -> 0x800000.
  - Without the macro: wrapped low 24 bits and clip=0.
- Commit boundary: write new gains during busy, then commit -> current sample uses the old gains; the next sample uses the new ones. A write with no commit is never applied.
- Overrun: second in_valid at cycle 5 -> overrun=1, single out_valid with the first sample's result; status_clr -> overrun=0.
- Abort and reset: run low at cycle 6 -> no out_valid, busy=0, out_data unchanged. Asserting reset_n low mid-MAC asynchronously zeroes every output.
